// File: rtl/controle_irrigacao.sv
// controle_irrigacao: irrigation master sequencer choosing sprinkler or drip,
// timing each cycle in seconds and pausing for tank refill when the tank runs dry.
module controle_irrigacao #(
  parameter int T_ASP = 300,
  parameter int T_GOT = 600,
  parameter int T_ENCHE = 120,
  parameter int W = 12
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         umSegundo,
  input  logic         buttonPulse,
  input  logic [1:0]   umidade,
  input  logic         chuva,
  input  logic [2:0]   nivelDagua,
  output logic         aspersao,
  output logic         gotejamento,
  output logic         casoEspecifico,
  output logic         valvulaEnche,
  output logic         concluido,
  output logic [W-1:0] restante,
  output logic [2:0]   estado
);
  typedef enum logic [2:0] {
    OCIOSO      = 3'd0,
    ASPERSAO    = 3'd1,
    GOTEJAMENTO = 3'd2,
    ENCHENDO    = 3'd3,
    FIM         = 3'd4,
    ERRO        = 3'd5
  } stateT;
  typedef enum logic [1:0] {NONE = 2'd0, MODE_ASP = 2'd1, MODE_GOT = 2'd2} modeT;
  stateT state, nState;
  modeT savedMode, nMode;
  logic [W-1:0] savedTime, nTime, nRest, dec;
  logic nivelOk, last;
  assign nivelOk = nivelDagua inside {3'b000, 3'b001, 3'b011, 3'b111};
  assign dec = restante - W'(1);
  // a tick on the last second ends the timed state instead of reaching zero
  assign last = umSegundo && restante == W'(1);
  assign estado = state;
  always_comb begin
    nState = state;
    nRest = restante;
    nMode = savedMode;
    nTime = savedTime;
    case (state)
      OCIOSO:
        if (buttonPulse) begin
          if (!nivelOk) begin
            nState = ERRO;
          end else if (!(chuva || umidade[1])) begin
            if (nivelDagua == 3'b000) begin
              nState = ENCHENDO;
              nRest = W'(T_ENCHE);
              nMode = NONE;
              nTime = '0;
            end else if (umidade == 2'b00 && nivelDagua == 3'b111) begin
              nState = ASPERSAO;
              nRest = W'(T_ASP);
            end else begin
              nState = GOTEJAMENTO;
              nRest = W'(T_GOT);
            end
          end
        end
      ASPERSAO, GOTEJAMENTO:
        if (buttonPulse || chuva) begin
          nState = OCIOSO;
          nRest = '0;
          nMode = NONE;
          nTime = '0;
        end else if (!nivelOk) begin
          nState = ERRO;
          nRest = '0;
        end else if (last) begin
          nState = FIM;
          nRest = '0;
        end else if (nivelDagua == 3'b000) begin
          nState = ENCHENDO;
          nRest = W'(T_ENCHE);
          nMode = state == ASPERSAO ? MODE_ASP : MODE_GOT;
          nTime = umSegundo ? dec : restante;
        end else begin
          nRest = umSegundo ? dec : restante;
          nState = (state == ASPERSAO && nivelDagua == 3'b001) ? GOTEJAMENTO : state;
        end
      ENCHENDO:
        if (buttonPulse) begin
          nState = OCIOSO;
          nRest = '0;
          nMode = NONE;
          nTime = '0;
        end else if (!nivelOk) begin
          nState = ERRO;
          nRest = '0;
        end else if (nivelDagua == 3'b111) begin
          nState = savedMode == MODE_ASP ? ASPERSAO : savedMode == MODE_GOT ? GOTEJAMENTO : OCIOSO;
          nRest = savedMode == NONE ? '0 : savedTime;
          nMode = NONE;
          nTime = '0;
        end else if (last) begin
          nState = ERRO;
          nRest = '0;
        end else if (umSegundo) begin
          nRest = dec;
        end
      FIM: begin
        nState = OCIOSO;
        nRest = '0;
      end
      ERRO: begin
        nRest = '0;
        if (buttonPulse && nivelOk) begin
          nState = OCIOSO;
          nMode = NONE;
          nTime = '0;
        end
      end
      default: begin
        nState = OCIOSO;
        nRest = '0;
        nMode = NONE;
        nTime = '0;
      end
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= OCIOSO;
      restante <= '0;
      savedMode <= NONE;
      savedTime <= '0;
      aspersao <= 1'b0;
      gotejamento <= 1'b0;
      casoEspecifico <= 1'b0;
      valvulaEnche <= 1'b0;
      concluido <= 1'b0;
    end else begin
      state <= nState;
      restante <= nRest;
      savedMode <= nMode;
      savedTime <= nTime;
      aspersao <= nState == ASPERSAO;
      gotejamento <= nState == GOTEJAMENTO;
      casoEspecifico <= nState == ENCHENDO || nState == ERRO;
      valvulaEnche <= nState == ENCHENDO;
      concluido <= nState == FIM;
    end
  end
endmodule

// File: tb/tb_controle_irrigacao.sv
// tb_controle_irrigacao: directed test-plan scenarios followed by randomized
// stimulus, every cycle compared against a behavioural model of the sequencer.
module tb_controle_irrigacao;
  localparam int T_ASP = 300, T_GOT = 600, T_ENCHE = 120, W = 12;
  logic clock = 0, reset = 0, umSegundo = 0, buttonPulse = 0, chuva = 0;
  logic [1:0] umidade = 0;
  logic [2:0] nivelDagua = 0;
  logic aspersao, gotejamento, casoEspecifico, valvulaEnche, concluido;
  logic [W-1:0] restante;
  logic [2:0] estado;
  int errors = 0, checks = 0;
  int mState, mRest, mMode, mTime;
  logic [2:0] goodLv [4] = '{3'b000, 3'b001, 3'b011, 3'b111};
  logic [2:0] badLv [4] = '{3'b010, 3'b100, 3'b101, 3'b110};

  controle_irrigacao #(.T_ASP(T_ASP), .T_GOT(T_GOT), .T_ENCHE(T_ENCHE), .W(W)) dut (
    .clock(clock), .reset(reset), .umSegundo(umSegundo), .buttonPulse(buttonPulse),
    .umidade(umidade), .chuva(chuva), .nivelDagua(nivelDagua), .aspersao(aspersao),
    .gotejamento(gotejamento), .casoEspecifico(casoEspecifico), .valvulaEnche(valvulaEnche),
    .concluido(concluido), .restante(restante), .estado(estado));

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mState = 0; mRest = 0; mMode = 0; mTime = 0;
  endtask

  task automatic goIdle(input bit clearSaved);
    mState = 0; mRest = 0;
    if (clearSaved) begin mMode = 0; mTime = 0; end
  endtask

  // states: 0 idle, 1 sprinkler, 2 drip, 3 filling, 4 done, 5 error; saved mode 0 = none
  task automatic model(input bit b, input bit t);
    bit ok = nivelDagua inside {3'b000, 3'b001, 3'b011, 3'b111};
    int left = mRest - int'(t);
    case (mState)
      0: if (b) begin
        if (!ok) mState = 5;
        else if (chuva || umidade >= 2) mState = 0;
        else if (nivelDagua == 0) begin mState = 3; mRest = T_ENCHE; mMode = 0; mTime = 0; end
        else if (umidade == 0 && nivelDagua == 7) begin mState = 1; mRest = T_ASP; end
        else begin mState = 2; mRest = T_GOT; end
      end
      1, 2: begin
        if (b || chuva) goIdle(1);
        else if (!ok) begin mState = 5; mRest = 0; end
        else if (left == 0) begin mState = 4; mRest = 0; end
        else if (nivelDagua == 0) begin mMode = mState; mTime = left; mState = 3; mRest = T_ENCHE; end
        else begin
          mRest = left;
          if (mState == 1 && nivelDagua == 1) mState = 2;
        end
      end
      3: begin
        if (b) goIdle(1);
        else if (!ok) begin mState = 5; mRest = 0; end
        else if (nivelDagua == 7) begin mState = mMode; mRest = mMode == 0 ? 0 : mTime; mMode = 0; mTime = 0; end
        else if (left == 0) begin mState = 5; mRest = 0; end
        else mRest = left;
      end
      4: goIdle(0);
      default: if (b && ok) goIdle(1);
    endcase
  endtask

  task automatic compareAll();
    check("estado", int'(estado), mState);
    if (mState != 5) check("restante", int'(restante), mRest);
    check("outputs", int'({aspersao, gotejamento, casoEspecifico, valvulaEnche, concluido}),
          int'({mState == 1, mState == 2, mState == 3 || mState == 5, mState == 3, mState == 4}));
  endtask

  task automatic step(input bit b, input bit t);
    buttonPulse = b; umSegundo = t;
    @(posedge clock);
    model(b, t);
    #1;
    compareAll();
    buttonPulse = 0; umSegundo = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 1);
  endtask

  initial begin
    modelReset();
    repeat (2) @(posedge clock);
    #2 reset = 1;
    #1 compareAll();
    // full sprinkler cycle
    umidade = 0; nivelDagua = 3'b111; chuva = 0;
    step(1, 0);
    check("asp_start", int'(restante), 300);
    ticks(299);
    step(0, 1);
    check("fim_pulse", int'(concluido), 1);
    step(0, 0);
    check("idle_after_fim", int'(estado), 0);
    // drip start, ticks, abort
    umidade = 1; nivelDagua = 3'b011;
    step(1, 0);
    check("got_start", int'(restante), 600);
    ticks(10);
    check("got_590", int'(restante), 590);
    step(1, 0);
    // sprinkler -> drip on low tank -> refill -> resume drip
    umidade = 0; nivelDagua = 3'b111;
    step(1, 0);
    ticks(100);
    nivelDagua = 3'b001;
    step(0, 0);
    check("asp_to_got", int'(restante), 200);
    nivelDagua = 3'b000;
    step(0, 0);
    check("fill_valve", int'(valvulaEnche), 1);
    ticks(5);
    nivelDagua = 3'b111;
    step(0, 0);
    check("resume_got", int'(restante), 200);
    step(1, 0);
    // fill timeout from idle start
    umidade = 1; nivelDagua = 3'b000;
    step(1, 0);
    ticks(120);
    check("fill_timeout", int'(estado), 5);
    nivelDagua = 3'b011;
    step(1, 0);
    // last tick with empty tank finishes; rain with tick aborts
    umidade = 0; nivelDagua = 3'b111;
    step(1, 0);
    ticks(299);
    nivelDagua = 3'b000;
    step(0, 1);
    check("fim_over_fill", int'(estado), 4);
    step(0, 0);
    nivelDagua = 3'b111;
    step(1, 0);
    chuva = 1;
    step(0, 1);
    check("rain_abort", int'(estado), 0);
    chuva = 0;
    // asynchronous reset mid-drip
    umidade = 1; nivelDagua = 3'b011;
    step(1, 0);
    ticks(3);
    #3 reset = 0;
    #1;
    modelReset();
    check("async_rst_outs", int'({aspersao, gotejamento, casoEspecifico, valvulaEnche, concluido}), 0);
    check("async_rst_rest", int'(restante), 0);
    @(posedge clock);
    #2 reset = 1;
    step(0, 1);
    chuva = 1;
    step(1, 0);
    check("rain_no_start", int'(estado), 0);
    chuva = 0; nivelDagua = 3'b101;
    step(1, 0);
    check("invalid_err", int'(estado), 5);
    nivelDagua = 3'b111;
    step(1, 0);
    // randomized phase
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(49) == 0) begin
        int r = $urandom_range(11);
        umidade = 2'($urandom_range(3));
        chuva = $urandom_range(7) == 0;
        nivelDagua = r < 10 ? goodLv[r % 4] : badLv[r % 4];
      end
      step($urandom_range(79) == 0, $urandom_range(3) != 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
